traffic_light_timer: RTL



---
 rtl/traffic_light_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/traffic_light_timer.sv
// traffic_light_timer: per-phase down-counter that produces the TIMEOUT level
// for the traffic-light FSM. It watches the one-hot {green,yellow,red} lights,
// reloads the phase duration on every phase change, counts down on tick, and
// holds time_out high once the interval has elapsed until the phase changes.
module traffic_light_timer #(
    parameter int COUNT_W      = 4,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int RED_TICKS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               green,
    input  logic               yellow,
    input  logic               red,
    output logic               time_out,
    output logic [COUNT_W-1:0] remaining,
    output logic               phase_err
);

    localparam logic [COUNT_W-1:0] L_GREEN  = COUNT_W'(GREEN_TICKS);
    localparam logic [COUNT_W-1:0] L_YELLOW = COUNT_W'(YELLOW_TICKS);
    localparam logic [COUNT_W-1:0] L_RED    = COUNT_W'(RED_TICKS);
    localparam logic [COUNT_W-1:0] L_ONE    = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] L_ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_phase;
    logic [COUNT_W-1:0] r_remaining;
    logic               r_time_out;
    logic               r_phase_err;

    logic [2:0]         w_p;
    logic               w_valid;
    logic               w_change;
    logic [COUNT_W-1:0] w_dur;

    assign w_p = {green, yellow, red};

    // Decode the phase vector: one-hot check and the duration of that phase.
    always_comb begin
        w_valid = 1'b0;
        w_dur   = L_ZERO;
        case (w_p)
            3'b100: begin w_valid = 1'b1; w_dur = L_GREEN;  end
            3'b010: begin w_valid = 1'b1; w_dur = L_YELLOW; end
            3'b001: begin w_valid = 1'b1; w_dur = L_RED;    end
            default: begin w_valid = 1'b0; w_dur = L_ZERO;  end
        endcase
    end

    // A fault stores the invalid vector as the phase, so any valid phase that
    // follows is seen as a change and always reloads.
    assign w_change = w_valid && (w_p != r_phase);

    // Timer FSM: invalid phase beats phase change, which beats counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= 3'b000;
            r_remaining <= L_ZERO;
            r_time_out  <= 1'b0;
            r_phase_err <= 1'b0;
        end else if (!w_valid) begin
            r_state     <= FAULT;
            r_phase     <= w_p;
            r_remaining <= L_ZERO;
            r_time_out  <= 1'b0;
            r_phase_err <= 1'b1;
        end else if (w_change) begin
            // Load wins over a coincident tick.
            r_phase     <= w_p;
            r_remaining <= w_dur;
            r_phase_err <= 1'b0;
            if (w_dur == L_ZERO) begin
                r_state    <= EXPIRED;
                r_time_out <= 1'b1;
            end else begin
                r_state    <= COUNT;
                r_time_out <= 1'b0;
            end
        end else begin
            case (r_state)
                COUNT: begin
                    if (tick) begin
                        if (r_remaining == L_ONE) begin
                            r_remaining <= L_ZERO;
                            r_state     <= EXPIRED;
                            r_time_out  <= 1'b1;
                        end else if (r_remaining > L_ONE) begin
                            r_remaining <= r_remaining - L_ONE;
                        end
                    end
                end
                EXPIRED: begin
                    // Dwell here until the FSM changes phase; no re-arm.
                    r_remaining <= L_ZERO;
                    r_time_out  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign time_out  = r_time_out;
    assign remaining = r_remaining;
    assign phase_err = r_phase_err;

endmodule
